// File: rtl/wim_scan_drv.sv
// Multiplexed 7-segment scan driver: NDIG x 7 pattern buffer, digits lit one at a time with optional dark gap.
// Latency: buffer write visible the next time that digit is lit; outputs decode registered state combinationally.
// Backpressure: in_ready drops only for a write aimed at the currently lit digit; all other offers accepted each cycle.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                scan enable; low forces IDLE (outputs dark, buffer kept)
//   in_valid/in_ready pattern write handshake; in_pat stored at in_dig (in_dig >= NDIG dropped)
//   seg_o, dig_o      segment pattern and one-hot digit select (zero when dark)
//   frame_o           pulse on the last lit cycle of digit NDIG-1
module wim_scan_drv #(
  parameter int NDIG  = 4,
  parameter int DWELL = 8,
  parameter int BLANK = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [6:0]                in_pat,
  input  logic [$clog2(NDIG)-1:0]   in_dig,
  output logic                      in_ready,
  output logic [6:0]                seg_o,
  output logic [NDIG-1:0]           dig_o,
  output logic                      frame_o
);

  localparam int DW   = $clog2(NDIG);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_cur;
  logic [CW-1:0]   r_cnt;
  logic [6:0]      r_buf [NDIG];

  logic [DW-1:0]   w_cur_nxt;
  logic            w_show;
  logic            w_dwell_end;
  logic            w_gap_end;
  logic            w_wr;

  assign w_show      = (r_state == S_SHOW);
  assign w_cur_nxt   = (r_cur == DW'(NDIG - 1)) ? '0 : r_cur + DW'(1);
  assign w_dwell_end = (r_cnt == CW'(DWELL - 1));
  // Unreachable when BLANK=0 since GAP is never entered.
  assign w_gap_end   = (r_cnt == CW'(BLANK - 1));

  // Refuse only writes to the lit digit so its pattern cannot change mid-dwell.
  assign in_ready = !(w_show && (in_dig == r_cur));
  // Out-of-range digit indices are handshaken but dropped.
  assign w_wr     = in_valid && in_ready && (int'(in_dig) < NDIG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_SHOW;
            r_cur   <= '0;
            r_cnt   <= '0;
          end
        end
        S_SHOW: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
          end else if (w_dwell_end) begin
            r_cnt <= '0;
            if (BLANK > 0) begin
              r_state <= S_GAP;
            end else begin
              r_cur <= w_cur_nxt;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
          end else if (w_gap_end) begin
            r_state <= S_SHOW;
            r_cnt   <= '0;
            r_cur   <= w_cur_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cur   <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIG; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_wr) begin
      r_buf[in_dig] <= in_pat;
    end
  end

  // Pure decode of registered state; async reset darkens outputs immediately.
  always_comb begin
    seg_o = '0;
    dig_o = '0;
    if (w_show) begin
      seg_o        = r_buf[r_cur];
      dig_o[r_cur] = 1'b1;
    end
  end

  assign frame_o = w_show && (r_cur == DW'(NDIG - 1)) && w_dwell_end;

endmodule

// File: tb/tb_wim_scan_drv.sv
module tb_wim_scan_drv;

  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int PER   = DWELL + BLANK;
  localparam int FRAME = NDIG * PER;
  localparam int DW    = $clog2(NDIG);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            in_valid = 1'b0;
  logic [6:0]      in_pat = '0;
  logic [DW-1:0]   in_dig = '0;
  logic            in_ready;
  logic [6:0]      seg_o;
  logic [NDIG-1:0] dig_o;
  logic            frame_o;

  always #5 clk = ~clk;

  wim_scan_drv #(.NDIG(NDIG), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_pat   (in_pat),
    .in_dig   (in_dig),
    .in_ready (in_ready),
    .seg_o    (seg_o),
    .dig_o    (dig_o),
    .frame_o  (frame_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: while scanning, m_p counts cycles since the scan (re)started;
  // the lit digit and phase follow from plain division by the slot length.
  bit         m_scan = 1'b0;
  int         m_p = 0;
  logic [6:0] m_buf [NDIG];
  bit         e_lit;
  int         e_d;
  int         e_off;

  int  cyc_no = 0;
  bit  track_frame = 1'b0;
  int  last_frame = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_view();
    int s;
    s     = m_p % FRAME;
    e_d   = s / PER;
    e_off = s % PER;
    e_lit = m_scan && (e_off < DWELL);
  endfunction

  task automatic check_outputs();
    logic [6:0]      es;
    logic [NDIG-1:0] ed;
    bit              ef;
    bit              er;
    m_view();
    es = e_lit ? m_buf[e_d] : 7'h00;
    ed = e_lit ? (NDIG'(1) << e_d) : '0;
    ef = e_lit && (e_d == NDIG - 1) && (e_off == DWELL - 1);
    er = !(e_lit && (int'(in_dig) == e_d));
    check("seg_o",    32'(seg_o),    32'(es));
    check("dig_o",    32'(dig_o),    32'(ed));
    check("frame_o",  32'(frame_o),  32'(ef));
    check("in_ready", 32'(in_ready), 32'(er));
  endtask

  task automatic model_edge();
    m_view();
    if (in_valid && !(e_lit && (int'(in_dig) == e_d)) && (int'(in_dig) < NDIG))
      m_buf[in_dig] = in_pat;
    if (!m_scan) begin
      if (en) begin
        m_scan = 1'b1;
        m_p    = 0;
      end
    end else if (!en) begin
      m_scan = 1'b0;
    end else begin
      m_p++;
    end
  endtask

  task automatic cycle(input bit e, input bit v, input logic [6:0] pat, input int d);
    @(negedge clk);
    en       = e;
    in_valid = v;
    in_pat   = pat;
    in_dig   = DW'(d);
    #1;
    check_outputs();
    if (track_frame && frame_o) begin
      if (last_frame >= 0) check("frame_gap", 32'(cyc_no - last_frame), 32'(FRAME));
      last_frame = cyc_no;
    end
    cyc_no++;
    @(posedge clk);
    model_edge();
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 99) < 95, $urandom_range(0, 2) == 0,
            7'($urandom), int'($urandom_range(0, NDIG - 1)));
    end
  endtask

  task automatic mid_reset();
    int n = 0;
    m_view();
    while (!e_lit && n < 50) begin
      cycle(1'b1, 1'b0, 7'h00, 0);
      m_view();
      n++;
    end
    check("reach_show", 32'(e_lit), 32'd1);
    #2;
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_seg",   32'(seg_o),    32'd0);
    check("rst_dig",   32'(dig_o),    32'd0);
    check("rst_frame", 32'(frame_o),  32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    m_scan = 1'b0;
    m_p    = 0;
    for (int i = 0; i < NDIG; i++) m_buf[i] = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NDIG; i++) m_buf[i] = '0;

    // Reset state while rst_n held low
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with en=0 and no writes stays dark
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 7'h00, 0);

    // Writes accepted while disabled, then continuous scan with frame spacing
    cycle(1'b0, 1'b1, 7'h7E, 0);
    cycle(1'b0, 1'b1, 7'h30, 1);
    track_frame = 1'b1;
    for (int i = 0; i < 70; i++) cycle(1'b1, 1'b0, 7'h00, 0);
    track_frame = 1'b0;
    check("frame_seen", 32'(last_frame >= 0), 32'd1);

    // Offer a write to the lit digit every cycle: blocked while lit, taken in the gap
    for (int i = 0; i < 2 * FRAME; i++) begin
      m_view();
      cycle(1'b1, 1'b1, 7'($urandom), e_lit ? e_d : int'($urandom_range(0, NDIG - 1)));
    end

    // Drop en mid-scan and re-enable
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 7'h00, 0);
    cycle(1'b0, 1'b0, 7'h00, 0);
    cycle(1'b0, 1'b0, 7'h00, 0);
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 7'h00, 0);

    random_run(1500);

    // Fill every digit, then async reset mid-SHOW; buffer must read back zero
    for (int i = 0; i < NDIG; i++) cycle(1'b0, 1'b1, 7'(8'h11 * (i + 1)), i);
    mid_reset();
    for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, 1'b0, 7'h00, 0);

    random_run(400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wim_scan_drv.md
WIM_SCAN_DRV -- requirements
Module: wim_scan_drv

Parameters
REQ-001 NDIG, 4: number of multiplexed digits; legal range 2..8.
REQ-002 DWELL, 8: cycles each digit is lit; legal range >=1.
REQ-003 BLANK, 1: dark cycles between digits; legal range >=0.

Interface
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 en  in  1  scan enable.
REQ-007 in_valid  in  1  a segment pattern is offered.
REQ-008 in_pat  in  7  7-bit segment pattern (po0..po6 of the upstream decoder; bit i = po_i).
REQ-009 in_dig  in  clog2(NDIG)  target digit index for in_pat.
REQ-010 in_ready  out  1  the offered pattern is accepted this cycle.
REQ-011 seg_o  out  7  segment drive for the lit digit.
REQ-012 dig_o  out  NDIG  one-hot digit select; all-zero when dark.
REQ-013 frame_o  out  1  one-cycle pulse on the last lit cycle of digit NDIG-1.

Function
REQ-014 The block SHALL hold an NDIG x 7 pattern buffer; a write occurs on a rising edge where in_valid=1 and in_ready=1; the buffer takes in_pat at index in_dig.
REQ-015 An in_dig value >= NDIG SHALL be accepted with in_ready=1 and discarded with no buffer change.
REQ-016 The FSM SHALL have states IDLE, SHOW and GAP, plus a current-digit index cur and a cycle counter cnt.
REQ-017 IDLE: if en=1, next state is SHOW with cur=0 and cnt=0.
REQ-018 SHOW: cnt increments each cycle; when cnt=DWELL-1, cnt clears and the next state is GAP if BLANK>0; otherwise the next state is SHOW with cur advanced.
REQ-019 GAP: cnt increments each cycle; when cnt=BLANK-1, cnt clears, cur advances, and the next state is SHOW.
REQ-020 cur SHALL advance modulo NDIG: NDIG-1 wraps to 0.
REQ-021 In SHOW, seg_o SHALL equal buf[cur] and dig_o SHALL be one-hot at bit cur; in IDLE and GAP, seg_o=0 and dig_o=0.
REQ-022 seg_o and dig_o SHALL be decoded only from registered state; a buffer write to a digit becomes visible the first cycle that digit is next in SHOW after the write edge.
REQ-023 in_ready SHALL be 0 exactly when state=SHOW and in_dig=cur, so the lit digit never changes mid-dwell; otherwise in_ready=1, including in IDLE and GAP.
REQ-024 frame_o SHALL be 1 exactly when state=SHOW, cur=NDIG-1 and cnt=DWELL-1.
REQ-025 en=0 sampled in SHOW or GAP SHALL force IDLE on the next edge, with cur=0, cnt=0 and outputs dark; the buffer is retained.
REQ-026 A write and a scan advance on the same edge SHALL both take effect; the write is stored before the advanced digit is next shown.
REQ-027 Writes SHALL be accepted while en=0.

Reset
REQ-028 While rst_n=0: state=IDLE, cur=0, cnt=0, all buffer entries 0, seg_o=0, dig_o=0, frame_o=0, in_ready=1.
REQ-029 Reset asserted mid-scan SHALL take effect immediately, without waiting for a clock edge; after release, the scan restarts at digit 0 only when en=1.

Verification (NDIG=4, DWELL=4, BLANK=1)
REQ-030 Reset release with en=0 and no writes -> seg_o=0, dig_o=0, frame_o=0 and in_ready=1 indefinitely.
REQ-031 Write 7'h7E to digit 0 and 7'h30 to digit 1, then en=1 -> seg_o=7'h7E with dig_o=4'b0001 for 4 cycles, then 1 dark cycle, then seg_o=7'h30 with dig_o=4'b0010 for 4 cycles.
REQ-032 Continuous scan -> frame_o pulses once every 20 cycles, coincident with dig_o=4'b1000 and its 4th lit cycle.
REQ-033 in_valid=1 with in_dig=cur during SHOW -> in_ready=0 and the buffer is unchanged; the write is accepted in the following GAP cycle.
REQ-034 en dropped during digit 2 -> outputs go dark on the next edge; en re-asserted -> the scan restarts at dig_o=4'b0001 with buffer contents intact.
REQ-035 rst_n pulsed low mid-SHOW -> outputs are 0 immediately and all buffer entries read 0 on the next scan.
